// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and subtractor state encoding.
// BCD_SUB_SIGN_MAG_EN adds the COMPLEMENT state used for sign-magnitude output.
package bcd_pkg;

  typedef logic [3:0] bcdDigit_t;

  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
`ifdef BCD_SUB_SIGN_MAG_EN
    , S_COMP
`endif
  } subState_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract: diff = a - b - borrowIn, borrowed back into 0..9.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       borrowIn,
  output logic [3:0] diff,
  output logic       borrowOut
);

  logic [4:0] t;

  // t spans -16..15, so bit 4 is the sign; out-of-range digits keep their raw low bits
  always_comb begin
    t         = {1'b0, a} - {1'b0, b} - {4'b0, borrowIn};
    borrowOut = t[4];
    diff      = t[4] ? (t[3:0] + 4'(BCD_BASE)) : t[3:0];
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial multi-digit BCD subtractor, LSD first, one digit per clock.
// Define BCD_SUB_SIGN_MAG_EN to return negative results as magnitude plus sign flag.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                startValid,
  output logic                startReady,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                borrowIn,
  output logic [4*DIGITS-1:0] diff,
  output logic                borrowOut,
  output logic                negative,
  output logic                invalidDigit,
  output logic                done
);

  localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  subState_t state, state_nx;

  logic [DIGITS-1:0][3:0] a_q, b_q, diff_q;
  logic [IW-1:0]          idx;
  logic                   borrow;
  bcdDigit_t              op_a, op_b, dig;
  logic                   dig_bo;
  logic                   accept, last;

  assign startReady = (state == S_IDLE) || (state == S_DONE);
  assign done       = (state == S_DONE);
  assign accept     = startValid && startReady;
  assign last       = (idx == LAST);
  assign diff       = diff_q;

  // One digit slice serves both passes; the complement pass computes 0 - diff
  always_comb begin
    op_a = a_q[idx];
    op_b = b_q[idx];
`ifdef BCD_SUB_SIGN_MAG_EN
    if (state == S_COMP) begin
      op_a = '0;
      op_b = diff_q[idx];
    end
`endif
  end

  bcd_digit_sub u_digit (
    .a        (op_a),
    .b        (op_b),
    .borrowIn (borrow),
    .diff     (dig),
    .borrowOut(dig_bo)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_RUN;
      S_RUN: begin
        if (last) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          state_nx = dig_bo ? S_COMP : S_DONE;
`else
          state_nx = S_DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      S_COMP: if (last) state_nx = S_DONE;
`endif
      S_DONE:  state_nx = accept ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nx;
  end

`ifdef BCD_SUB_SIGN_MAG_EN
  logic neg_q;
  assign negative = neg_q;
`else
  assign negative = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      idx          <= '0;
      borrow       <= 1'b0;
      borrowOut    <= 1'b0;
      invalidDigit <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_q        <= 1'b0;
`endif
    end else if (accept) begin
      a_q          <= a;
      b_q          <= b;
      idx          <= '0;
      borrow       <= borrowIn;
      invalidDigit <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_q        <= 1'b0;
`endif
    end else if (state == S_RUN) begin
      diff_q[idx]  <= dig;
      borrow       <= dig_bo;
      idx          <= idx + 1'b1;
      invalidDigit <= invalidDigit | (op_a > 4'(BCD_MAX)) | (op_b > 4'(BCD_MAX));
      if (last) begin
        borrowOut <= dig_bo;
        idx       <= '0;
        borrow    <= 1'b0;
      end
    end
`ifdef BCD_SUB_SIGN_MAG_EN
    else if (state == S_COMP) begin
      diff_q[idx] <= dig;
      borrow      <= dig_bo;
      idx         <= idx + 1'b1;
      if (last) neg_q <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial: directed cases plus random ops against an integer model.
module tb_bcd_sub_serial;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clock, resetN, startValid, startReady, borrowIn;
  logic [W-1:0] a, b, diff;
  logic         borrowOut, negative, invalidDigit, done;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clock(clock), .resetN(resetN), .startValid(startValid), .startReady(startReady),
    .a(a), .b(b), .borrowIn(borrowIn), .diff(diff), .borrowOut(borrowOut),
    .negative(negative), .invalidDigit(invalidDigit), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic on the operand values
  task automatic model(input logic [W-1:0] ma, mb, input logic mbin,
                       output logic [W-1:0] d, output logic bo, neg, output int lat);
    int val;
    val = bcd2int(ma) - bcd2int(mb) - int'(mbin);
    bo  = (val < 0);
    neg = 1'b0;
    lat = DIGITS + 1;
    if (val < 0) begin
`ifdef BCD_SUB_SIGN_MAG_EN
      d   = int2bcd(-val);
      neg = 1'b1;
      lat = 2 * DIGITS + 1;
`else
      d = int2bcd(val + 10 ** DIGITS);
`endif
    end else begin
      d = int2bcd(val);
    end
  endtask

  // Drive one accept, then scramble inputs and wait (bounded) for done; lat=0 on timeout
  task automatic run_op(input logic [W-1:0] ra, rb, input logic rbin, output int lat,
                        output logic [W-1:0] d, output logic bo, neg, inv);
    @(negedge clock);
    a = ra; b = rb; borrowIn = rbin; startValid = 1'b1;
    @(posedge clock);
    #1;
    startValid = 1'b0;
    a = W'($urandom); b = W'($urandom); borrowIn = 1'($urandom);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done) begin
        lat = c;
        break;
      end
    end
    d = diff; bo = borrowOut; neg = negative; inv = invalidDigit;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++; if (diff !== '0) begin n_fail++; $display("FAIL reset_diff got %h want 0", diff); end
    n_checks++; if ({borrowOut, negative, invalidDigit, done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {borrowOut, negative, invalidDigit, done}); end
    n_checks++; if (startReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", startReady); end
    resetN = 1'b1;
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] ta, tb_, input logic tbin);
    logic [W-1:0] d, ed;
    logic bo, neg, inv, ebo, eneg;
    int lat, elat;
    model(ta, tb_, tbin, ed, ebo, eneg, elat);
    run_op(ta, tb_, tbin, lat, d, bo, neg, inv);
    n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", nm, lat, elat); end
    n_checks++; if (d !== ed) begin n_fail++; $display("FAIL %s_diff got %h want %h", nm, d, ed); end
    n_checks++; if ({bo, neg} !== {ebo, eneg}) begin
      n_fail++; $display("FAIL %s_borrow_neg got %b%b want %b%b", nm, bo, neg, ebo, eneg); end
    n_checks++; if (inv !== 1'b0) begin n_fail++; $display("FAIL %s_invalid got %b want 0", nm, inv); end
  endtask

  task automatic test_basic();
    check_op("basic", 16'h1234, 16'h0567, 1'b0);
    @(negedge clock);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", done); end
  endtask

  task automatic test_negative();
    check_op("negative", 16'h0003, 16'h0005, 1'b0);
  endtask

  task automatic test_wrap();
    check_op("wrap", 16'h0000, 16'h0000, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      check_op("random", int2bcd($urandom_range(0, 9999)), int2bcd($urandom_range(0, 9999)),
               1'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ed;
    logic ebo, eneg;
    int elat, cnt;
    @(negedge clock);
    a = 16'h5000; b = 16'h0001; borrowIn = 1'b0; startValid = 1'b1;
    @(posedge clock);
    #1;
    a = 16'h9999; b = 16'h9999;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done) begin cnt = c; break; end
    end
    n_checks++; if (cnt !== DIGITS + 1) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", cnt, DIGITS + 1); end
    n_checks++; if (diff !== 16'h4999) begin n_fail++; $display("FAIL b2b_first_diff got %h want 4999", diff); end
    n_checks++; if (startReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done got %b want 1", startReady); end
    @(posedge clock);
    #1;
    startValid = 1'b0;
    model(16'h9999, 16'h9999, 1'b0, ed, ebo, eneg, elat);
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done) begin cnt = c; break; end
    end
    n_checks++; if (cnt !== elat) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", cnt, elat); end
    n_checks++; if ({diff, borrowOut} !== {ed, ebo}) begin
      n_fail++; $display("FAIL b2b_second got %h/%b want %h/%b", diff, borrowOut, ed, ebo); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clock);
    a = 16'h1234; b = 16'h0567; borrowIn = 1'b0; startValid = 1'b1;
    @(posedge clock);
    #1;
    startValid = 1'b0;
    @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    n_checks++; if ({diff, borrowOut, negative, invalidDigit, done} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got %h/%b%b%b%b want all 0", diff, borrowOut, negative, invalidDigit, done); end
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      seen = seen | done;
    end
    resetN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      seen = seen | done;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done got %b want 0", seen); end
    n_checks++; if (startReady !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", startReady); end
    check_op("after_reset", 16'h1234, 16'h0567, 1'b0);
  endtask

  task automatic test_invalid();
    logic [W-1:0] d;
    logic bo, neg, inv;
    int lat;
    run_op(16'h000A, 16'h0001, 1'b0, lat, d, bo, neg, inv);
    n_checks++; if (inv !== 1'b1) begin n_fail++; $display("FAIL invalid_flag got %b want 1", inv); end
    n_checks++; if (d !== 16'h0009) begin n_fail++; $display("FAIL invalid_diff got %h want 0009", d); end
    n_checks++; if (lat !== DIGITS + 1) begin n_fail++; $display("FAIL invalid_latency got %0d want %0d", lat, DIGITS + 1); end
    check_op("invalid_clear", 16'h0002, 16'h0001, 1'b0);
  endtask

  initial begin
    resetN = 1'b0; startValid = 1'b0; a = '0; b = '0; borrowIn = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_basic();
    test_negative();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_invalid();
    test_random();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
